// File: rtl/cnn_load_ctrl_if.sv
// Bus bundle between the CNN load/compute sequencer and its host: byte stream
// in, RAM write port and status out, datapath result in, captured result out.
interface cnn_load_ctrl_if #(
    parameter int DW           = 8,
    parameter int DATA_DEPTH   = 64,
    parameter int WEIGHT_DEPTH = 54
);
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam int WAW = $clog2(WEIGHT_DEPTH);

    logic           mode;
    logic [DW-1:0]  din;
    logic           din_valid;
    logic           clear;
    logic           data_wen;
    logic [DAW-1:0] data_waddr;
    logic           weight_wen;
    logic [WAW-1:0] weight_waddr;
    logic [DW-1:0]  wdata;
    logic           data_full;
    logic           weight_full;
    logic           overflow;
    logic           calc_start;
    logic           busy;
    logic [DW-1:0]  result_in;
    logic [DW-1:0]  dout;
    logic           out_valid;
    logic           out_data_flag;

    modport master (
        output mode, din, din_valid, clear, result_in,
        input  data_wen, data_waddr, weight_wen, weight_waddr, wdata,
               data_full, weight_full, overflow, calc_start, busy,
               dout, out_valid, out_data_flag
    );

    modport slave (
        input  mode, din, din_valid, clear, result_in,
        output data_wen, data_waddr, weight_wen, weight_waddr, wdata,
               data_full, weight_full, overflow, calc_start, busy,
               dout, out_valid, out_data_flag
    );
endinterface

// File: rtl/cnn_load_ctrl.sv
// Load/compute sequencer: fills the data and weight RAM banks from a tagged byte
// stream, then times the combinational datapath and captures its result.
module cnn_load_ctrl #(
    parameter int DW           = 8,
    parameter int DATA_DEPTH   = 64,
    parameter int WEIGHT_DEPTH = 54,
    parameter int CALC_LAT     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    cnn_load_ctrl_if.slave      bus
);
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam int WAW = $clog2(WEIGHT_DEPTH);
    localparam int CW  = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;

    typedef enum logic [1:0] {LOAD, CALC, DONE} state_t;

    state_t         state;
    state_t         state_next;
    logic [DAW-1:0] data_cnt;
    logic [WAW-1:0] weight_cnt;
    logic [CW-1:0]  calc_cnt;
    logic           data_accept;
    logic           weight_accept;
    logic           drop;
    logic           calc_last;

    logic           data_wen_q;
    logic [DAW-1:0] data_waddr_q;
    logic           weight_wen_q;
    logic [WAW-1:0] weight_waddr_q;
    logic [DW-1:0]  wdata_q;
    logic           data_full_q;
    logic           weight_full_q;
    logic           overflow_q;
    logic           calc_start_q;
    logic           busy_q;
    logic [DW-1:0]  dout_q;
    logic           out_valid_q;
    logic           out_data_flag_q;

    // clear overrides everything, including a concurrent beat, which is then
    // neither written nor counted as an overflow.
    always_comb begin
        state_next    = state;
        data_accept   = 1'b0;
        weight_accept = 1'b0;
        drop          = 1'b0;
        calc_last     = (state == CALC) && (calc_cnt == CW'(CALC_LAT - 1));
        if (bus.clear) begin
            state_next = LOAD;
        end else begin
            case (state)
                LOAD: begin
                    if (bus.din_valid) begin
                        if (!bus.mode && !data_full_q) begin
                            data_accept = 1'b1;
                        end else if (bus.mode && !weight_full_q) begin
                            weight_accept = 1'b1;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                    if (data_full_q && weight_full_q) begin
                        state_next = CALC;
                    end
                end
                CALC: begin
                    drop = bus.din_valid;
                    if (calc_last) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    drop = bus.din_valid;
                end
                default: begin
                    state_next = LOAD;
                end
            endcase
        end
    end

    // Counters stop at DEPTH-1 once the bank is full, so they never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= LOAD;
            data_cnt       <= '0;
            weight_cnt     <= '0;
            calc_cnt       <= '0;
            data_wen_q     <= 1'b0;
            data_waddr_q   <= '0;
            weight_wen_q   <= 1'b0;
            weight_waddr_q <= '0;
            wdata_q        <= '0;
            data_full_q    <= 1'b0;
            weight_full_q  <= 1'b0;
            overflow_q     <= 1'b0;
            calc_start_q   <= 1'b0;
            busy_q         <= 1'b0;
            dout_q         <= '0;
            out_valid_q    <= 1'b0;
            out_data_flag_q <= 1'b0;
        end else begin
            state        <= state_next;
            data_wen_q   <= data_accept;
            weight_wen_q <= weight_accept;
            calc_start_q <= (state == LOAD) && (state_next == CALC);
            busy_q       <= (state_next == CALC);
            out_valid_q  <= calc_last && !bus.clear;
            calc_cnt     <= (state == CALC && !bus.clear && !calc_last) ? calc_cnt + 1'b1 : '0;

            if (data_accept || weight_accept) begin
                wdata_q <= bus.din;
            end
            if (data_accept) begin
                data_waddr_q <= data_cnt;
                if (data_cnt == DAW'(DATA_DEPTH - 1)) begin
                    data_full_q <= 1'b1;
                end else begin
                    data_cnt <= data_cnt + 1'b1;
                end
            end
            if (weight_accept) begin
                weight_waddr_q <= weight_cnt;
                if (weight_cnt == WAW'(WEIGHT_DEPTH - 1)) begin
                    weight_full_q <= 1'b1;
                end else begin
                    weight_cnt <= weight_cnt + 1'b1;
                end
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (calc_last && !bus.clear) begin
                dout_q          <= bus.result_in;
                out_data_flag_q <= (bus.result_in != '0);
            end

            if (bus.clear) begin
                data_cnt       <= '0;
                weight_cnt     <= '0;
                data_waddr_q   <= '0;
                weight_waddr_q <= '0;
                data_full_q    <= 1'b0;
                weight_full_q  <= 1'b0;
                overflow_q     <= 1'b0;
            end
        end
    end

    assign bus.data_wen      = data_wen_q;
    assign bus.data_waddr    = data_waddr_q;
    assign bus.weight_wen    = weight_wen_q;
    assign bus.weight_waddr  = weight_waddr_q;
    assign bus.wdata         = wdata_q;
    assign bus.data_full     = data_full_q;
    assign bus.weight_full   = weight_full_q;
    assign bus.overflow      = overflow_q;
    assign bus.calc_start    = calc_start_q;
    assign bus.busy          = busy_q;
    assign bus.dout          = dout_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_data_flag = out_data_flag_q;
endmodule

// File: doc/cnn_load_ctrl.md
Name: cnn_load_ctrl

Overview:
Parametrised load/compute sequencer for the CNN inference path. Accepts a byte stream tagged by `mode` and auto-addresses it into a data RAM bank and a weight RAM bank. Once both banks are full it launches the combinational conv/pool/fc datapath, waits a configurable settle latency, then captures and presents the result with a valid pulse. Adds the valid-qualified input, full/overflow status, restart and result handshake that the first-generation top lacked.

Parameters:
DW, 8, data/weight/result word width in bits
DATA_DEPTH, 64, data RAM words (8x8x1 image); must be >= 2
WEIGHT_DEPTH, 54, weight RAM words (3x3x3x2); must be >= 2
CALC_LAT, 4, cycles between calc_start and result capture; must be >= 1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mode  in  1  0 = beat targets data bank, 1 = beat targets weight bank
din  in  DW  input byte
din_valid  in  1  beat qualifier
clear  in  1  synchronous restart to LOAD
data_wen  out  1  data RAM write strobe
data_waddr  out  $clog2(DATA_DEPTH)  data RAM write address
weight_wen  out  1  weight RAM write strobe
weight_waddr  out  $clog2(WEIGHT_DEPTH)  weight RAM write address
wdata  out  DW  shared RAM write data
data_full  out  1  data bank completely written
weight_full  out  1  weight bank completely written
overflow  out  1  sticky: a beat was dropped
calc_start  out  1  one-cycle pulse starting the datapath
busy  out  1  high in CALC
result_in  in  DW  datapath result (combinational from RAM contents)
dout  out  DW  captured result
out_valid  out  1  one-cycle pulse when dout updates
out_data_flag  out  1  registered (result != 0), updated with dout

Behaviour:
- Reset: all outputs 0; state LOAD; both address counters 0.
- States: LOAD, CALC, DONE.
- LOAD, beat accepted at edge N (din_valid=1, clear=0, target bank not full):
  - During cycle N+1: the target wen=1, waddr=current count, wdata=din.
  - The bank counter increments.
  - Beats to the other bank are unaffected; interleaving is allowed.
- Fill: accepting beat DEPTH-1 of a bank sets its full flag in cycle N+1, concurrent with that final wen. No counter wrap occurs.
- Drops: a beat to an already-full bank is dropped, produces no wen, and sets overflow. A din_valid beat in CALC or DONE is also dropped and sets overflow.
- LOAD->CALC: at the first edge with data_full=1 and weight_full=1 registered.
  - calc_start=1 and busy=1 in the first CALC cycle.
  - The final RAM write has already completed at that edge.
- CALC: an internal counter runs 0..CALC_LAT-1, starting from the calc_start cycle. At the edge where counter==CALC_LAT-1:
  - dout<=result_in and out_data_flag<=(result_in!=0).
  - out_valid=1 for the next cycle.
  - State moves to DONE; busy drops.
- Latency: last accepted beat at edge N gives calc_start in cycle N+2 and out_valid in cycle N+2+CALC_LAT.
- DONE: dout and out_data_flag hold; out_valid=0. The block waits for clear.
- clear (any state): next state LOAD; counters, full flags, overflow, calc counter and busy cleared; calc_start and out_valid forced 0.
  - dout and out_data_flag are held until the next capture.
  - clear wins over a simultaneous din_valid; the beat is dropped and does NOT set overflow.
  - clear in CALC aborts the calculation: no out_valid is produced.
- Async reset mid-operation returns everything to reset values immediately, including dout.
- Widths: addresses use $clog2(DEPTH); counters compare against DEPTH-1 (non-power-of-2 depths allowed).

Test Plan:
- Defaults; 64 mode=0 beats (din=addr), then 54 mode=1 beats, back-to-back -> data_waddr 0..63 and weight_waddr 0..53 each with a single wen; full flags set; calc_start 2 cycles after the last beat; out_valid 4 cycles later; dout=result_in.
- Interleave data/weight beats with random din_valid gaps -> addresses strictly sequential per bank; no lost or duplicated writes; overflow=0.
- After data_full, send 3 extra mode=0 beats -> no data_wen; overflow=1 sticky; weight loading still completes normally.
- Datapath model returns 0 -> out_valid=1 with dout=0 and out_data_flag=0; model returns 0x5A -> out_data_flag=1.
- Assert clear in the second CALC cycle together with din_valid -> no out_valid; state LOAD; counters 0; overflow=0; previous dout held.
- Deassert rst_n while at data_waddr=30 -> all outputs 0 asynchronously; a full reload after release completes normally.
